// File: rtl/updown_cnt_seq_ctrl.sv
// Sequencer for a W-bit enable/direction up/down counter: takes a target over valid/ready,
// steps the counter along the shorter wrap-around path, then verifies it and reports done/err.
module updown_cnt_seq_ctrl #(
   parameter int W      = 2,
   parameter int SETTLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [W-1:0] req_target,
   input  logic         abort,
   input  logic [W-1:0] cnt_ps,
   output logic         cnt_e,
   output logic         cnt_x,
   output logic         busy,
   output logic         done,
   output logic         err
);

   typedef enum logic [2:0] {
      S_IDLE, S_CALC, S_RUN, S_CHECK, S_DONE, S_ERR
   } state_e;

   localparam int         SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [W:0] HALF = (W+1)'(2 ** (W - 1));

   state_e          state_q, state_d;
   logic [W-1:0]    tgt_q, tgt_d;
   logic [W-1:0]    rem_q, rem_d;
   logic            dir_q, dir_d;
   logic [SW-1:0]   settle_q, settle_d;
   logic            ready_q, ready_d;
   logic [W-1:0]    diff;

   always_comb begin
      // NOTE: every next-state value gets a default first so no path infers a latch.
      state_d  = state_q;
      tgt_d    = tgt_q;
      rem_d    = rem_q;
      dir_d    = dir_q;
      settle_d = settle_q;
      ready_d  = ready_q;
      diff     = tgt_q - cnt_ps;

      case (state_q)
         S_IDLE: begin
            // ready rises one cycle after entering IDLE, since ready_q enters IDLE low
            ready_d = 1'b1;
            if (req_valid && ready_q) begin
               tgt_d   = req_target;
               dir_d   = 1'b0;
               ready_d = 1'b0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            if (diff == '0) begin
               state_d = S_DONE;
            end else if ({1'b0, diff} <= HALF) begin
               dir_d   = 1'b1;
               rem_d   = diff;
               state_d = S_RUN;
            end else begin
               dir_d   = 1'b0;
               rem_d   = ~diff + W'(1);
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (rem_q == W'(1)) begin
               settle_d = '0;
               state_d  = S_CHECK;
            end else begin
               rem_d = rem_q - W'(1);
            end
         end
         S_CHECK: begin
            if (settle_q == SW'(SETTLE - 1)) begin
               state_d = (cnt_ps == tgt_q) ? S_DONE : S_ERR;
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end
         S_DONE, S_ERR: state_d = S_IDLE;
         default:       state_d = S_IDLE;
      endcase

      if (abort && (state_q == S_CALC || state_q == S_RUN || state_q == S_CHECK)) begin
         state_d = S_IDLE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         tgt_q    <= '0;
         rem_q    <= '0;
         dir_q    <= 1'b0;
         settle_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         tgt_q    <= tgt_d;
         rem_q    <= rem_d;
         dir_q    <= dir_d;
         settle_q <= settle_d;
         ready_q  <= ready_d;
      end
   end

   // Moore outputs: decoded from registered state only; dir_q is cleared on accept
   assign req_ready = ready_q;
   assign cnt_e     = (state_q == S_RUN);
   assign cnt_x     = (state_q != S_IDLE) && dir_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_updown_cnt_seq_ctrl.sv
// Directed bench for updown_cnt_seq_ctrl: a vector table of single operations against a
// behavioural 2-bit counter, plus hand sequences for reset, abort and held requests.
module tb_updown_cnt_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_target = '0;
   logic       abort = 1'b0;
   logic [1:0] cnt_ps = '0;
   logic       cnt_e, cnt_x, busy, done, err;

   logic       load_en = 1'b0;
   logic [1:0] load_val = '0;
   logic       frozen = 1'b0;

   int checks = 0;
   int failures = 0;

   updown_cnt_seq_ctrl #(.W(2), .SETTLE(1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_target(req_target), .abort(abort), .cnt_ps(cnt_ps), .cnt_e(cnt_e),
      .cnt_x(cnt_x), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Counter being sequenced; frozen models a stuck counter that ignores e
   always @(posedge clk) begin
      if (load_en)                cnt_ps <= load_val;
      else if (cnt_e && !frozen)  cnt_ps <= cnt_x ? cnt_ps + 2'd1 : cnt_ps - 2'd1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0] ps;
      logic [1:0] tgt;
      logic       frz;
      int         n_e;
      logic       x;
      int         done_at;
      int         err_at;
      logic [1:0] fin;
   } vec_t;

   vec_t vecs[7];

   task automatic load_ps(input logic [1:0] v);
      load_en  = 1'b1;
      load_val = v;
      @(negedge clk);
      load_en  = 1'b0;
   endtask

   // Called and returns at a negedge; samples cycles C1..C8 after the accept edge
   task automatic run_vec(input int idx, input vec_t v);
      int   n_e, first_e, done_at, err_at, end_at;
      logic x_e, x_done;
      logic rdy[1:8];
      string tag;
      n_e = 0; first_e = 0; done_at = 0; err_at = 0; x_e = 1'b0; x_done = 1'b0;
      tag = $sformatf("v%0d", idx);
      frozen = v.frz;
      load_ps(v.ps);
      check({tag, "_ready_idle"}, req_ready, 1);
      req_valid  = 1'b1;
      req_target = v.tgt;
      @(negedge clk);
      req_valid  = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) @(negedge clk);
         if (c == 1) check({tag, "_busy_c1"}, busy, 1);
         if (cnt_e) begin
            n_e++;
            if (first_e == 0) begin first_e = c; x_e = cnt_x; end
         end
         if (done && done_at == 0) begin done_at = c; x_done = cnt_x; end
         if (err && err_at == 0) err_at = c;
         rdy[c] = req_ready;
      end
      check({tag, "_e_cycles"}, n_e, v.n_e);
      check({tag, "_first_e"}, first_e, (v.n_e > 0) ? 2 : 0);
      if (v.n_e > 0) check({tag, "_x_run"}, x_e, v.x);
      else           check({tag, "_x_done_zero"}, x_done, 0);
      check({tag, "_done_at"}, done_at, v.done_at);
      check({tag, "_err_at"}, err_at, v.err_at);
      check({tag, "_final_ps"}, cnt_ps, v.fin);
      end_at = v.done_at + v.err_at;
      if (end_at > 0 && end_at + 2 <= 8) begin
         check({tag, "_ready_low_after"}, rdy[end_at + 1], 0);
         check({tag, "_ready_back"}, rdy[end_at + 2], 1);
      end
      frozen = 1'b0;
   endtask

   initial begin
      bit   bad;
      int   done_at;
      //        ps     tgt    frz   n_e x     done err fin
      vecs[0] = '{2'd0, 2'd3, 1'b0, 1, 1'b0, 4, 0, 2'd3};  // shorter path is down
      vecs[1] = '{2'd1, 2'd3, 1'b0, 2, 1'b1, 5, 0, 2'd3};  // tie goes up
      vecs[2] = '{2'd2, 2'd2, 1'b0, 0, 1'b0, 2, 0, 2'd2};  // already there
      vecs[3] = '{2'd0, 2'd1, 1'b1, 1, 1'b1, 0, 4, 2'd0};  // stuck counter -> err
      vecs[4] = '{2'd3, 2'd1, 1'b0, 2, 1'b1, 5, 0, 2'd1};  // tie across wrap
      vecs[5] = '{2'd0, 2'd1, 1'b0, 1, 1'b1, 4, 0, 2'd1};
      vecs[6] = '{2'd2, 2'd1, 1'b0, 1, 1'b0, 4, 0, 2'd1};

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_outputs", {req_ready, cnt_e, cnt_x, busy, done, err}, 0);
      rst = 1'b1;
      #1 check("ready_at_release", req_ready, 0);
      @(negedge clk);
      check("ready_after_release", req_ready, 1);

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      // Mid-operation reset: outputs clear at once and the request is dropped
      load_ps(2'd0);
      req_valid = 1'b1; req_target = 2'd2;
      @(negedge clk);                     // C1
      req_valid = 1'b0;
      @(negedge clk);                     // C2
      check("rst_seq_run_e", cnt_e, 1);
      #2 rst = 1'b0;
      #1 check("rst_midop_outputs", {req_ready, cnt_e, cnt_x, busy, done, err}, 0);
      @(negedge clk);
      rst = 1'b1;
      bad = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (busy || cnt_e || done || err) bad = 1'b1;
         if (c == 0) check("rst_ready_next_cycle", req_ready, 1);
      end
      check("rst_not_resumed", bad, 0);

      // Abort in first RUN cycle, with the request held high throughout
      load_ps(2'd0);
      req_valid = 1'b1; req_target = 2'd2;
      @(negedge clk);                     // C1 CALC
      check("abort_busy_calc", busy, 1);
      @(negedge clk);                     // C2 RUN
      check("abort_run_e", cnt_e, 1);
      abort = 1'b1;
      @(negedge clk);                     // C3 IDLE
      abort = 1'b0;
      check("abort_outputs", {cnt_e, busy, done, err, req_ready}, 0);
      check("abort_ps_stepped", cnt_ps, 1);
      @(negedge clk);                     // C4 IDLE, ready back
      check("abort_ready_back", req_ready, 1);
      check("held_not_accepted_early", busy, 0);
      @(negedge clk);                     // held request accepted -> CALC
      check("held_accepted", busy, 1);
      req_valid = 1'b0;
      done_at = 0; bad = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (c > 1) @(negedge clk);
         if (err) bad = 1'b1;
         if (done && done_at == 0) done_at = c;
      end
      check("held_done_at", done_at, 4);
      check("held_no_err", bad, 0);
      check("held_final_ps", cnt_ps, 2);

      // abort in IDLE has no effect
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle_ready", req_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
